interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, number of fetch-stall cycles that drain in-flight instructions before the context push.
REQ-002 Parameter INT_VECTOR, default 32'h0000_0002, PC value loaded on interrupt entry.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 INT  input  1  external interrupt request; the rising edge is significant.
REQ-006 rti_mem  input  1  RTI instruction is in the memory stage this cycle.
REQ-007 pc_in  input  32  fetch-stage PC.
REQ-008 flags_in  input  3  current CCR.
REQ-009 mem_data_in  input  16  stack data, valid the cycle after pop.
REQ-010 stall_fetch  output  1  freeze PC and the fetch/decode register.
REQ-011 flush  output  1  clear the fetch/decode and decode/execute registers.
REQ-012 push, pop  output  1 each  stack push/pop strobe to the memory stage.
REQ-013 counter_value  output  2  push/pop word index: 00 = PC high, 01 = PC low, 10 = flags.
REQ-014 push_data  output  16  word being pushed.
REQ-015 pc_load  output  1  load pc_out into PC.
REQ-016 pc_out  output  32  target PC.
REQ-017 flags_load, flags_out  output  1, 3  restore the CCR.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 An INT rising edge SHALL set pending; pending SHALL clear on entry to PUSH_PCH; edges arriving while pending is already set are merged.
REQ-020 States: IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_FLG, JUMP, POP_FLG, POP_PCL, POP_PCH, RESUME, LOAD.
REQ-021 IDLE: rti_mem -> POP_FLG; else pending -> DRAIN; rti_mem SHALL win over a simultaneous pending.
REQ-022 DRAIN entry SHALL capture pc_in and flags_in into pc_saved/flg_saved and load the drain counter with DRAIN_CYCLES-1; the counter decrements each cycle; at 0 -> PUSH_PCH.
REQ-023 stall_fetch SHALL be 1 in every state from DRAIN through LOAD inclusive.
REQ-024 PUSH_PCH/PUSH_PCL/PUSH_FLG: push=1 for exactly one cycle each, counter_value 00/01/10, push_data = pc_saved[31:16] / pc_saved[15:0] / {13'b0, flg_saved}.
REQ-025 JUMP: pc_load=1, pc_out=INT_VECTOR, flush=1 for one cycle, then -> IDLE.
REQ-026 POP_FLG/POP_PCL/POP_PCH: pop=1 for one cycle each, counter_value 10/01/00.
REQ-027 mem_data_in SHALL be captured one cycle after each pop: flags[2:0] at the end of POP_PCL, PC low at the end of POP_PCH, PC high at the end of RESUME.
REQ-028 LOAD: pc_load=1, pc_out = restored PC, flags_load=1, flags_out = restored flags, flush=1 for one cycle, then -> IDLE.
REQ-029 An INT edge during any return or entry sequence SHALL stay pending and be serviced from IDLE after the current sequence completes.
REQ-030 Interrupt entry latency from INT edge to the JUMP pc_load SHALL be DRAIN_CYCLES+5 cycles.
REQ-031 All outputs SHALL be registered.
REQ-032 push and pop SHALL never be high in the same cycle.
REQ-033 Unused outputs SHALL be 0 in every state.

Reset
REQ-034 RESET SHALL force IDLE, pending=0, counter=0, and all outputs, pc_saved and flg_saved to 0, immediately and asynchronously.
REQ-035 RESET mid-sequence SHALL abort the sequence with no further push, pop or pc_load.
REQ-036 pending SHALL not be set by an INT level that is already high at RESET release; only a new rising edge sets it.

Structure
REQ-037 State encoding and counter_value codes SHALL live in a shared include file used by the memory stage.
REQ-038 A single sub-module, int_edge_detect (INT rising-edge register), is permitted; everything else is one module.

Verification
REQ-039 INT pulse with pc_in=32'h0001_2345, flags=3'b101 -> three pushes 16'h0001, 16'h2345, 16'h0005 with codes 00/01/10, then pc_load with pc_out=32'h0000_0002, 8 cycles after the edge.
REQ-040 rti_mem with pops returning 16'h0003, 16'h2345, 16'h0001 -> LOAD cycle shows pc_out=32'h0001_2345, flags_out=3'b011, flush=1.
REQ-041 rti_mem and pending INT in the same IDLE cycle -> return sequence first, then a full entry sequence without a new INT edge.
REQ-042 RESET asserted during PUSH_PCL -> outputs 0 in the same cycle, no pc_load, IDLE after release.
REQ-043 Two INT edges during DRAIN -> exactly one entry sequence.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller and the memory stage:
// controller state encoding and stack word index codes.
package interrupt_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DRAIN    = 4'd1,
    ST_PUSH_PCH = 4'd2,
    ST_PUSH_PCL = 4'd3,
    ST_PUSH_FLG = 4'd4,
    ST_JUMP     = 4'd5,
    ST_POP_FLG  = 4'd6,
    ST_POP_PCL  = 4'd7,
    ST_POP_PCH  = 4'd8,
    ST_RESUME   = 4'd9,
    ST_LOAD     = 4'd10
  } state_t;

  // Stack word index carried on counter_value during push/pop.
  localparam logic [1:0] CV_PC_HI = 2'b00;
  localparam logic [1:0] CV_PC_LO = 2'b01;
  localparam logic [1:0] CV_FLAGS = 2'b10;

endpackage

// File: rtl/interrupt_controller_int_edge_detect.sv
// Registered rising-edge detector for the external interrupt line.
// The first cycle after reset only arms the detector, so a line that is
// already high when reset releases never looks like a new edge.
module int_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic armed;
  logic level_q;

  // Track previous level and emit a one-cycle registered pulse on 0->1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      armed   <= 1'b1;
      level_q <= level;
      rise    <= armed & level & ~level_q;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry/return sequencer: drains the pipeline, pushes PC and CCR
// to the stack and jumps to the vector on an interrupt; pops CCR and PC and
// reloads them on RTI.
//
// Strobe semantics: push and pop are single-cycle strobes; every high cycle
// is exactly one stack word, identified by counter_value (and push_data for
// pushes). The memory stage always accepts; there is no back-pressure. Pop
// data is expected on mem_data_in in the cycle after the pop strobe.
import interrupt_controller_pkg::*;

module interrupt_controller #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0002
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        INT,
  input  logic        rti_mem,
  input  logic [31:0] pc_in,
  input  logic [2:0]  flags_in,
  input  logic [15:0] mem_data_in,
  output logic        stall_fetch,
  output logic        flush,
  output logic        push,
  output logic        pop,
  output logic [1:0]  counter_value,
  output logic [15:0] push_data,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        flags_load,
  output logic [2:0]  flags_out,
  output logic        busy,
  output state_t      state_dbg
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state, state_d;
  logic            int_rise;
  logic            pending;
  logic [CW-1:0]   drain_cnt;
  logic [31:0]     pc_saved;
  logic [2:0]      flg_saved;
  logic [15:0]     pc_lo_rest;
  logic [2:0]      flg_rest;

  logic            stall_d, flush_d, push_d, pop_d, pc_load_d, flags_load_d, busy_d;
  logic [1:0]      cv_d;
  logic [15:0]     push_data_d;
  logic [31:0]     pc_out_d;
  logic [2:0]      flags_out_d;

  int_edge_detect u_edge (
    .clk   (clk),
    .rst   (RESET),
    .level (INT),
    .rise  (int_rise)
  );

  assign state_dbg = state;

  // Next-state selection; RTI in the memory stage beats a pending interrupt.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (rti_mem)      state_d = ST_POP_FLG;
        else if (pending) state_d = ST_DRAIN;
      end
      ST_DRAIN:    if (drain_cnt == '0) state_d = ST_PUSH_PCH;
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_FLG;
      ST_PUSH_FLG: state_d = ST_JUMP;
      ST_JUMP:     state_d = ST_IDLE;
      ST_POP_FLG:  state_d = ST_POP_PCL;
      ST_POP_PCL:  state_d = ST_POP_PCH;
      ST_POP_PCH:  state_d = ST_RESUME;
      ST_RESUME:   state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, pending flag, drain counter, saved context and restored words.
  // Entering PUSH_PCH consumes the request: any edge registered while the
  // drain was running is merged into this entry.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      drain_cnt  <= '0;
      pc_saved   <= '0;
      flg_saved  <= '0;
      pc_lo_rest <= '0;
      flg_rest   <= '0;
    end else begin
      state <= state_d;
      if (state == ST_DRAIN && state_d == ST_PUSH_PCH) pending <= 1'b0;
      else if (int_rise)                                pending <= 1'b1;
      if (state == ST_IDLE && state_d == ST_DRAIN) begin
        pc_saved  <= pc_in;
        flg_saved <= flags_in;
        drain_cnt <= CW'(DRAIN_CYCLES - 1);
      end else if (state == ST_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
      if (state == ST_POP_PCL) flg_rest   <= mem_data_in[2:0];
      if (state == ST_POP_PCH) pc_lo_rest <= mem_data_in;
    end
  end

  // Output values for the upcoming state; PC high is taken straight from
  // the bus on the RESUME -> LOAD edge.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    stall_d      = busy_d;
    flush_d      = 1'b0;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    cv_d         = CV_PC_HI;
    push_data_d  = '0;
    pc_load_d    = 1'b0;
    pc_out_d     = '0;
    flags_load_d = 1'b0;
    flags_out_d  = '0;
    case (state_d)
      ST_PUSH_PCH: begin push_d = 1'b1; cv_d = CV_PC_HI; push_data_d = pc_saved[31:16]; end
      ST_PUSH_PCL: begin push_d = 1'b1; cv_d = CV_PC_LO; push_data_d = pc_saved[15:0]; end
      ST_PUSH_FLG: begin push_d = 1'b1; cv_d = CV_FLAGS; push_data_d = {13'b0, flg_saved}; end
      ST_JUMP: begin
        pc_load_d = 1'b1;
        pc_out_d  = INT_VECTOR;
        flush_d   = 1'b1;
      end
      ST_POP_FLG: begin pop_d = 1'b1; cv_d = CV_FLAGS; end
      ST_POP_PCL: begin pop_d = 1'b1; cv_d = CV_PC_LO; end
      ST_POP_PCH: begin pop_d = 1'b1; cv_d = CV_PC_HI; end
      ST_LOAD: begin
        pc_load_d    = 1'b1;
        pc_out_d     = {mem_data_in, pc_lo_rest};
        flags_load_d = 1'b1;
        flags_out_d  = flg_rest;
        flush_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register stage.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      stall_fetch   <= 1'b0;
      flush         <= 1'b0;
      push          <= 1'b0;
      pop           <= 1'b0;
      counter_value <= '0;
      push_data     <= '0;
      pc_load       <= 1'b0;
      pc_out        <= '0;
      flags_load    <= 1'b0;
      flags_out     <= '0;
      busy          <= 1'b0;
    end else begin
      stall_fetch   <= stall_d;
      flush         <= flush_d;
      push          <= push_d;
      pop           <= pop_d;
      counter_value <= cv_d;
      push_data     <= push_data_d;
      pc_load       <= pc_load_d;
      pc_out        <= pc_out_d;
      flags_load    <= flags_load_d;
      flags_out     <= flags_out_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios with literal
// expectations plus randomized traffic against a schedule-based model.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam int          W   = 60;
  localparam int          DC  = 3;
  localparam logic [31:0] VEC = 32'h0000_0002;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  logic        INT = 1'b0, rti_mem = 1'b0;
  logic [31:0] pc_in = '0;
  logic [2:0]  flags_in = '0;
  logic [15:0] mem_data_in = '0;
  logic        stall_fetch, flush, push, pop, pc_load, flags_load, busy;
  logic [1:0]  counter_value;
  logic [15:0] push_data;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  state_t      state_dbg;

  interrupt_controller #(.DRAIN_CYCLES(DC), .INT_VECTOR(VEC)) dut (
    .clk(clk), .RESET(RESET), .INT(INT), .rti_mem(rti_mem), .pc_in(pc_in),
    .flags_in(flags_in), .mem_data_in(mem_data_in), .stall_fetch(stall_fetch),
    .flush(flush), .push(push), .pop(pop), .counter_value(counter_value),
    .push_data(push_data), .pc_load(pc_load), .pc_out(pc_out),
    .flags_load(flags_load), .flags_out(flags_out), .busy(busy),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [W-1:0] pack(input logic st, input logic fl, input logic pu,
      input logic po, input logic [1:0] cv, input logic [15:0] pd, input logic pl,
      input logic [31:0] pco, input logic fld, input logic [2:0] fo, input logic bz);
    return {st, fl, pu, po, cv, pd, pl, pco, fld, fo, bz};
  endfunction

  logic [W-1:0] act;
  assign act = pack(stall_fetch, flush, push, pop, counter_value, push_data, pc_load,
                    pc_out, flags_load, flags_out, busy);

  // ---------------- behavioural model ----------------
  // Each service sequence is a list of per-cycle output words appended to
  // exp_q; cap_q tags words whose cycle latches bus data (1 flags, 2 PC low,
  // 3 PC high), whose word is filled from the restored context (4), or that
  // consume the interrupt request (5). Edges are timestamped by clock count.
  logic [W-1:0] exp_q[$];
  int           cap_q[$];
  int           edges[$];
  int           keep[$];
  logic [W-1:0] cur_exp = '0;
  int           cur_cap = 0;
  logic         cur_idle = 1'b1;
  int           cyc = 0;
  logic         int_prev = 1'b0, prev_ok = 1'b0, pend;
  logic [2:0]   r_flg = '0;
  logic [15:0]  r_pcl = '0, r_pch = '0;

  task automatic enq(input logic [W-1:0] v, input int c);
    exp_q.push_back(v);
    cap_q.push_back(c);
  endtask

  task automatic enq_entry(input logic [31:0] pc, input logic [2:0] f);
    for (int i = 0; i < DC; i++)
      enq(pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 0);
    enq(pack(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, pc[31:16], 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 5);
    enq(pack(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, pc[15:0], 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 0);
    enq(pack(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, {13'b0, f}, 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 0);
    enq(pack(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 1'b1, VEC, 1'b0, 3'b0, 1'b1), 0);
  endtask

  task automatic enq_return();
    enq(pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 0);
    enq(pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 1);
    enq(pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 2);
    enq(pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 32'h0, 1'b0, 3'b0, 1'b1), 3);
    enq('0, 4);
  endtask

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      exp_q.delete(); cap_q.delete(); edges.delete();
      cur_exp = '0; cur_cap = 0; cur_idle = 1'b1; cyc = 0;
      prev_ok = 1'b0; int_prev = 1'b0;
    end else begin
      cyc++;
      case (cur_cap)
        1: r_flg = mem_data_in[2:0];
        2: r_pcl = mem_data_in;
        3: r_pch = mem_data_in;
        default: ;
      endcase
      if (prev_ok && INT && !int_prev) edges.push_back(cyc);
      int_prev = INT;
      prev_ok  = 1'b1;
      if (cur_idle && exp_q.size() == 0) begin
        pend = 1'b0;
        foreach (edges[i]) if (edges[i] <= cyc - 2) pend = 1'b1;
        if (rti_mem)   enq_return();
        else if (pend) enq_entry(pc_in, flags_in);
      end
      if (exp_q.size() > 0) begin
        cur_exp  = exp_q.pop_front();
        cur_cap  = cap_q.pop_front();
        cur_idle = 1'b0;
        if (cur_cap == 4)
          cur_exp = pack(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 1'b1, {r_pch, r_pcl},
                         1'b1, r_flg, 1'b1);
        if (cur_cap == 5) begin
          keep.delete();
          foreach (edges[i]) if (edges[i] > cyc - 1) keep.push_back(edges[i]);
          edges = keep;
        end
      end else begin
        cur_exp  = '0;
        cur_cap  = 0;
        cur_idle = 1'b1;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    n_cmp++;
    if (act !== cur_exp) begin
      n_bad++;
      $display("FAIL outputs t=%0t act=%h exp=%h", $time, act, cur_exp);
    end
  end

  // ---------------- driver / literal-check tasks ----------------
  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int          lat, npush, nload;
  logic [15:0] pd_seen[3];
  logic [1:0]  cv_seen[3];
  logic [31:0] ld_pc[2];
  logic        ld_fl[2];

  initial begin
    INT = 1'b1;  // high across reset release: must not count as an edge
    wait_neg(2);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    check("reset_pc_out", 64'(pc_out), 64'(0));
    RESET = 1'b0;
    wait_neg(8);
    check("level_at_release_busy", 64'(busy), 64'(0));
    INT = 1'b0;
    wait_neg(3);

    // Entry: pushes and latency.
    pc_in = 32'h0001_2345; flags_in = 3'b101; INT = 1'b1;
    lat = -1; npush = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) INT = 1'b0;
      if (push && npush < 3) begin pd_seen[npush] = push_data; cv_seen[npush] = counter_value; npush++; end
      if (pc_load && lat < 0) begin
        lat = k - 1;
        check("jump_pc_out", 64'(pc_out), 64'(32'h0000_0002));
        check("jump_flush", 64'(flush), 64'(1));
      end
    end
    check("entry_latency", 64'(lat), 64'(8));
    check("push_count", 64'(npush), 64'(3));
    check("push0_data", 64'(pd_seen[0]), 64'(16'h0001));
    check("push1_data", 64'(pd_seen[1]), 64'(16'h2345));
    check("push2_data", 64'(pd_seen[2]), 64'(16'h0005));
    check("push0_cv", 64'(cv_seen[0]), 64'(2'b00));
    check("push1_cv", 64'(cv_seen[1]), 64'(2'b01));
    check("push2_cv", 64'(cv_seen[2]), 64'(2'b10));

    // Return: pop data 0003 / 2345 / 0001.
    rti_mem = 1'b1;
    @(negedge clk); rti_mem = 1'b0;
    @(negedge clk); mem_data_in = 16'h0003;
    @(negedge clk); mem_data_in = 16'h2345;
    @(negedge clk); mem_data_in = 16'h0001;
    @(negedge clk);
    check("load_pc_load", 64'(pc_load), 64'(1));
    check("load_pc_out", 64'(pc_out), 64'(32'h0001_2345));
    check("load_flags_out", 64'(flags_out), 64'(3'b011));
    check("load_flags_load", 64'(flags_load), 64'(1));
    check("load_flush", 64'(flush), 64'(1));
    mem_data_in = '0;
    wait_neg(4);

    // RTI and pending in the same idle cycle: return first, then entry.
    INT = 1'b1;
    nload = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) INT = 1'b0;
      if (k == 2) rti_mem = 1'b1;
      if (k == 3) rti_mem = 1'b0;
      if (pc_load && nload < 2) begin ld_pc[nload] = pc_out; ld_fl[nload] = flags_load; nload++; end
    end
    check("rti_first_count", 64'(nload), 64'(2));
    check("rti_first_is_return", 64'(ld_fl[0]), 64'(1));
    check("then_entry_vec", 64'(ld_pc[1]), 64'(VEC));
    check("then_entry_noflags", 64'(ld_fl[1]), 64'(0));

    // Reset during PUSH_PCL.
    pc_in = 32'hABCD_1234; INT = 1'b1;
    @(negedge clk); INT = 1'b0;
    wait_neg(6);
    check("pcl_push", 64'(push), 64'(1));
    check("pcl_cv", 64'(counter_value), 64'(2'b01));
    #1 RESET = 1'b1;
    #1;
    check("rst_push", 64'(push), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_push_data", 64'(push_data), 64'(0));
    @(negedge clk); RESET = 1'b0;
    nload = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (pc_load || push || pop) nload++;
    end
    check("after_rst_activity", 64'(nload), 64'(0));
    check("after_rst_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Two further edges during DRAIN merge into one entry.
    INT = 1'b1;
    nload = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      case (k)
        1, 3, 5: INT = 1'b0;
        2, 4:    INT = 1'b1;
        default: ;
      endcase
      if (pc_load) nload++;
    end
    check("merged_entries", 64'(nload), 64'(1));

    // Randomized traffic checked by the per-cycle scoreboard.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) INT = ~INT;
      rti_mem     = ($urandom_range(0, 19) == 0);
      pc_in       = $urandom;
      flags_in    = 3'($urandom_range(0, 7));
      mem_data_in = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 499) == 0) begin
        #2 RESET = 1'b1;
        @(negedge clk);
        #2 RESET = 1'b0;
      end
    end
    INT = 1'b0; rti_mem = 1'b0;
    wait_neg(40);
    check("final_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
